// File: rtl/button_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module      : button_conditioner_if
// Description : Raw button/switch inputs and conditioned command outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface button_conditioner_if;
    logic btn_left;
    logic btn_right;
    logic btn_up;
    logic sw_stop;
    logic rpt_en;
    logic left;
    logic right;
    logic up;
    logic stop;

    modport master (
        output btn_left, btn_right, btn_up, sw_stop, rpt_en,
        input  left, right, up, stop
    );

    modport slave (
        input  btn_left, btn_right, btn_up, sw_stop, rpt_en,
        output left, right, up, stop
    );
endinterface
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : button_conditioner
// Description : Synchronise, debounce and pulse-encode push buttons, with
//               auto-repeat on up and a debounced run/enable switch.
// Revision    : 1.0 - initial release
// ============================================================================
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic                   clk,
    input  logic                   reset,
    button_conditioner_if.slave    bus
);

    localparam int c_NUM_IN    = 4;
    localparam int c_IDX_LEFT  = 0;
    localparam int c_IDX_RIGHT = 1;
    localparam int c_IDX_UP    = 2;
    localparam int c_IDX_STOP  = 3;

    localparam int c_CNT_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int c_HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int c_HOLD_W = $clog2(c_HOLD_MAX);

    localparam logic [c_CNT_W-1:0]  c_DB_LAST     = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_HOLD_W-1:0] c_DELAY_LAST  = c_HOLD_W'(REPEAT_DELAY - 1);
    localparam logic [c_HOLD_W-1:0] c_PERIOD_LAST = c_HOLD_W'(REPEAT_PERIOD - 1);

    typedef enum logic [0:0] {
        RPT_DELAY  = 1'b0,
        RPT_PERIOD = 1'b1
    } rpt_state_t;

    logic [c_NUM_IN-1:0] raw;
    logic [c_NUM_IN-1:0] stable_cur;
    logic [c_NUM_IN-1:0] stable_nxt;
    logic [c_NUM_IN-1:0] rise;

    assign raw = {bus.sw_stop, bus.btn_up, bus.btn_right, bus.btn_left};

    generate
        for (genvar gi = 0; gi < c_NUM_IN; gi++) begin : g_input
            logic               s1_q, s1_d;
            logic               s2_q, s2_d;
            logic               stable_q, stable_d;
            logic [c_CNT_W-1:0] cnt_q, cnt_d;

            always_comb begin
                s1_d     = raw[gi];
                s2_d     = s1_q;
                stable_d = stable_q;
                cnt_d    = '0;
                // Accept the new level only after DEBOUNCE_CYCLES consecutive mismatches.
                if (s2_q != stable_q) begin
                    if (cnt_q == c_DB_LAST) begin
                        stable_d = s2_q;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    s1_q     <= 1'b0;
                    s2_q     <= 1'b0;
                    stable_q <= 1'b0;
                    cnt_q    <= '0;
                end else begin
                    s1_q     <= s1_d;
                    s2_q     <= s2_d;
                    stable_q <= stable_d;
                    cnt_q    <= cnt_d;
                end
            end

            assign stable_cur[gi] = stable_q;
            assign stable_nxt[gi] = stable_d;
        end
    endgenerate

    rpt_state_t          rpt_state_q, rpt_state_d;
    logic [c_HOLD_W-1:0] hold_q, hold_d;
    logic                rpt_fire;
    logic                run;
    logic                left_q, left_d;
    logic                right_q, right_d;
    logic                up_q, up_d;
    logic                stop_q, stop_d;

    always_comb begin
        rise        = stable_nxt & ~stable_cur;
        run         = stable_nxt[c_IDX_STOP];
        hold_d      = hold_q;
        rpt_state_d = rpt_state_q;
        rpt_fire    = 1'b0;

        // Hold timing runs regardless of stop; only the emitted pulses are gated.
        if (rise[c_IDX_UP]) begin
            hold_d      = '0;
            rpt_state_d = RPT_DELAY;
        end else if (stable_nxt[c_IDX_UP] && bus.rpt_en) begin
            if ((rpt_state_q == RPT_DELAY  && hold_q == c_DELAY_LAST) ||
                (rpt_state_q == RPT_PERIOD && hold_q == c_PERIOD_LAST)) begin
                rpt_fire    = 1'b1;
                hold_d      = '0;
                rpt_state_d = RPT_PERIOD;
            end else begin
                hold_d = hold_q + 1'b1;
            end
        end else begin
            hold_d      = '0;
            rpt_state_d = RPT_DELAY;
        end

        left_d  = run & rise[c_IDX_LEFT]  & ~rise[c_IDX_RIGHT];
        right_d = run & rise[c_IDX_RIGHT] & ~rise[c_IDX_LEFT];
        up_d    = run & (rise[c_IDX_UP] | rpt_fire);
        stop_d  = stable_nxt[c_IDX_STOP];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rpt_state_q <= RPT_DELAY;
            hold_q      <= '0;
            left_q      <= 1'b0;
            right_q     <= 1'b0;
            up_q        <= 1'b0;
            stop_q      <= 1'b0;
        end else begin
            rpt_state_q <= rpt_state_d;
            hold_q      <= hold_d;
            left_q      <= left_d;
            right_q     <= right_d;
            up_q        <= up_d;
            stop_q      <= stop_d;
        end
    end

    assign bus.left  = left_q;
    assign bus.right = right_q;
    assign bus.up    = up_q;
    assign bus.stop  = stop_q;

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_conditioner
// Description : Scoreboard bench with a window-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_conditioner;
    localparam int DB   = 4;
    localparam int RD   = 8;
    localparam int RP   = 3;
    localparam int MAXC = 2000;

    logic clk = 1'b0;
    logic reset;
    button_conditioner_if bus ();

    button_conditioner #(
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Per-edge history of what was applied and what the model believes.
    logic [3:0] raw_h [MAXC];
    logic       rst_h [MAXC];
    logic       rpt_h [MAXC];
    logic [3:0] stab  [MAXC];

    int         n      = 0;
    int         anchor = 0;
    int         checks = 0;
    int         passed = 0;
    int         edge_cnt = 0;
    int         exp_cyc [$];
    logic [2:0] exp_val [$];
    logic       exp_stop [$];
    logic [2:0] mon_o;
    int         c_pop;
    logic [2:0] v_pop;
    logic       s_pop;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (ok) passed++;
        else $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_cnt - 1);
    endtask

    // Synchronised level seen by the debouncer at edge j.
    function automatic logic sync_val(int j, int i);
        if (j < 2) return 1'b0;
        if (rst_h[j-1] || rst_h[j-2]) return 1'b0;
        return raw_h[j-2][i];
    endfunction

    task automatic tick();
        logic [3:0] prev, rise, cur;
        logic       flip, run, press, rep;
        logic [2:0] v;
        int         d;
        @(posedge clk);
        raw_h[n] = {bus.sw_stop, bus.btn_up, bus.btn_right, bus.btn_left};
        rst_h[n] = reset;
        rpt_h[n] = bus.rpt_en;
        prev = (n == 0) ? 4'd0 : stab[n-1];
        if (reset) begin
            stab[n] = 4'd0;
            anchor  = n;
            exp_stop.push_back(1'b0);
        end else begin
            cur = prev;
            for (int i = 0; i < 4; i++) begin
                flip = 1'b1;
                for (int j = n - DB + 1; j <= n; j++) begin
                    if (j < 0) flip = 1'b0;
                    else if (rst_h[j] || sync_val(j, i) == prev[i]) flip = 1'b0;
                end
                if (flip) cur[i] = ~prev[i];
            end
            stab[n] = cur;
            rise  = cur & ~prev;
            run   = cur[3];
            press = rise[2];
            rep   = 1'b0;
            if (press) anchor = n;
            else if (cur[2] && rpt_h[n]) begin
                d = n - anchor;
                if (d == RD || (d > RD && (d - RD) % RP == 0)) rep = 1'b1;
            end else anchor = n;
            v = {run & (press | rep), run & rise[1] & ~rise[0], run & rise[0] & ~rise[1]};
            if (v != 3'b000) begin
                exp_cyc.push_back(n);
                exp_val.push_back(v);
            end
            exp_stop.push_back(cur[3]);
        end
        n++;
        #2;
    endtask

    task automatic ticks(input int k);
        for (int i = 0; i < k; i++) tick();
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            mon_o = {bus.up, bus.right, bus.left};
            if (exp_stop.size() > 0) begin
                s_pop = exp_stop.pop_front();
                chk(bus.stop === s_pop, "stop", int'(bus.stop), int'(s_pop));
            end
            while (exp_cyc.size() > 0 && exp_cyc[0] < edge_cnt - 1) begin
                c_pop = exp_cyc.pop_front();
                v_pop = exp_val.pop_front();
                chk(1'b0, "missed_pulse", 0, int'(v_pop));
            end
            if (mon_o !== 3'b000) begin
                if (exp_cyc.size() == 0) begin
                    chk(1'b0, "unexpected_pulse", int'(mon_o), 0);
                end else begin
                    c_pop = exp_cyc.pop_front();
                    v_pop = exp_val.pop_front();
                    chk(c_pop == edge_cnt - 1, "pulse_edge", edge_cnt - 1, c_pop);
                    chk(mon_o === v_pop, "pulse_kind", int'(mon_o), int'(v_pop));
                end
            end
        end
    end

    initial begin : stimulus
        int hold_left [4];
        logic [3:0] val;
        reset = 1'b1;
        bus.btn_left = 1'b0; bus.btn_right = 1'b0; bus.btn_up = 1'b0;
        bus.sw_stop = 1'b1;  bus.rpt_en = 1'b0;
        ticks(3);
        reset = 1'b0;
        ticks(8);
        // Single held left press, then release.
        bus.btn_left = 1'b1; ticks(15);
        bus.btn_left = 1'b0; ticks(10);
        // Short glitch on right.
        bus.btn_right = 1'b1; ticks(3);
        bus.btn_right = 1'b0; ticks(10);
        // Simultaneous left and right.
        bus.btn_left = 1'b1; bus.btn_right = 1'b1; ticks(15);
        bus.btn_left = 1'b0; bus.btn_right = 1'b0; ticks(10);
        // Auto-repeat on held up, then release.
        bus.rpt_en = 1'b1; bus.btn_up = 1'b1; ticks(25);
        bus.btn_up = 1'b0; ticks(10);
        // Stop switch low suppresses up.
        bus.sw_stop = 1'b0; ticks(10);
        bus.btn_up = 1'b1; ticks(15);
        bus.btn_up = 1'b0; ticks(10);
        bus.sw_stop = 1'b1; ticks(10);
        // Reset for one edge nine edges after the up press.
        bus.btn_up = 1'b1; ticks(14);
        reset = 1'b1; ticks(1);
        reset = 1'b0; ticks(25);
        bus.btn_up = 1'b0; ticks(10);

        for (int i = 0; i < 4; i++) hold_left[i] = 0;
        val = 4'b1000;
        for (int c = 0; c < 1300; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (hold_left[i] == 0) begin
                    val[i] = (i == 3) ? ($urandom_range(0, 7) != 0) : 1'($urandom_range(0, 1));
                    hold_left[i] = $urandom_range(1, 14);
                end else begin
                    hold_left[i]--;
                end
            end
            bus.btn_left  = val[0];
            bus.btn_right = val[1];
            bus.btn_up    = val[2];
            bus.sw_stop   = val[3];
            if ($urandom_range(0, 39) == 0) bus.rpt_en = ~bus.rpt_en;
            reset = ($urandom_range(0, 249) == 0);
            tick();
        end
        reset = 1'b0;
        bus.btn_left = 1'b0; bus.btn_right = 1'b0; bus.btn_up = 1'b0;
        ticks(12);
        @(negedge clk);
        @(negedge clk);
        chk(exp_cyc.size() == 0, "pending_pulses", exp_cyc.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, SHALL set the consecutive stable cycles needed to accept a level change (legal range 2..2^20).
REQ-002 Parameter REPEAT_DELAY, default 25000000, SHALL set the cycles from the initial up press pulse to the first auto-repeat pulse (legal range >= 2).
REQ-003 Parameter REPEAT_PERIOD, default 10000000, SHALL set the cycles between later auto-repeat pulses (legal range >= 2).
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-006 btn_left, btn_right, btn_up  input  1 each  SHALL be raw, asynchronous, active-high push buttons.
REQ-007 sw_stop  input  1  SHALL be the raw, asynchronous, active-high run/enable slide switch.
REQ-008 rpt_en  input  1  SHALL enable auto-repeat on up when high; it is synchronous to clk.
REQ-009 left, right, up  output  1 each  SHALL be registered single-cycle command pulses to the digit-editor stage.
REQ-010 stop  output  1  SHALL be the registered, debounced level of sw_stop.

Function
REQ-011 Each raw input SHALL pass through its own 2-flop synchronizer (s1, s2) before any other logic.
REQ-012 Each input SHALL have a debounced state bit `stable` and a counter `cnt` sized for DEBOUNCE_CYCLES-1.
REQ-013 On an edge where s2 == stable: cnt <= 0.
REQ-014 On an edge where s2 != stable and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
REQ-015 On an edge where s2 != stable and cnt == DEBOUNCE_CYCLES-1: stable <= s2 and cnt <= 0.
REQ-016 Latency SHALL be as follows: with edge 0 being the first edge that samples a raw input high and the input held high, stable SHALL rise at edge DEBOUNCE_CYCLES+1.
REQ-017 A raw glitch shorter than DEBOUNCE_CYCLES cycles SHALL not change stable and SHALL produce no pulse.
REQ-018 A press pulse SHALL be registered high for exactly one cycle at the edge where a button's stable goes 0->1; release (1->0) produces no pulse.
REQ-019 stop SHALL equal the stable bit of sw_stop.
REQ-020 While stop is 0, left, right and up SHALL be forced to 0; debouncing and hold timing continue and missed pulses are not replayed.
REQ-021 If left and right press pulses would fire on the same edge, neither SHALL be emitted.
REQ-022 Auto-repeat SHALL use a hold counter that clears at the up press pulse edge and increments each edge while up stable is 1.
REQ-023 With rpt_en=1 and up held, extra up pulses SHALL fire REPEAT_DELAY edges after the press pulse, then every REPEAT_PERIOD edges.
REQ-024 When up stable falls, or rpt_en goes 0, repeat pulses SHALL stop immediately and the hold counter SHALL clear.
REQ-025 A repeat pulse never coincides with a press pulse, and up SHALL never be high on two consecutive cycles.
REQ-026 Any counter SHALL saturate or clear as specified above and never wrap during a held press.

Reset
REQ-027 When reset=1 at an edge, all synchronizer flops, stable bits, counters and outputs SHALL be set to 0.
REQ-028 A button still held when reset deasserts SHALL go through full synchronization and debounce (REQ-016) before its press pulse.
REQ-029 Reset asserted mid-debounce or mid-repeat SHALL abort the operation with no pulse on the reset edge.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3)
REQ-030 Precondition: sw_stop high from reset release; after >=6 edges, stop=1. Stimulus: btn_left high at edge 0 and held. Required response: left=1 only in the cycle after edge 5; no later pulses; right=up=0.
REQ-031 Stimulus: btn_right pulsed high for 3 cycles, then low. Required response: right stays 0 and stable stays 0.
REQ-032 Stimulus: btn_left and btn_right rise on the same edge and are held. Required response: left=right=0 throughout.
REQ-033 Stimulus: rpt_en=1 and btn_up held with the press pulse at edge P. Required response: up pulses at P, P+8, P+11 and P+14. Stimulus: release. Required response: no pulse after stable falls.
REQ-034 Stimulus: sw_stop=0 (stop=0) and btn_up pressed. Required response: up stays 0.
REQ-035 Stimulus: reset for one edge at P+9 during a held up. Required response: outputs are 0; the next up pulse comes 5 edges after reset release (debounce restart), with no repeat before it.
